wb_queue: RTL and testbench
===========================

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Parameter WIDTH, default `WORD_WIDTH (32), register data width in bits.
REQ-002 Parameter REG_COUNT, default `REG_COUNT (32), registers in the downstream regfile; ADDR_WIDTH = $clog2(REG_COUNT).
REQ-003 Parameter DEPTH, default 4, queue entries; power of two, minimum 2.
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 in_valid  in  1  producer offers a register write this cycle.
REQ-007 in_ready  out  1  queue accepts the offered write this cycle.
REQ-008 in_addr  in  ADDR_WIDTH  destination register of the offered write.
REQ-009 in_data  in  WIDTH  value of the offered write.
REQ-010 wr_stall  in  1  regfile write port unavailable this cycle.
REQ-011 addr_d  out  ADDR_WIDTH  regfile write address (head entry).
REQ-012 we_d  out  1  regfile write enable.
REQ-013 d  out  WIDTH  regfile write data (head entry).
REQ-014 rd_addr_a / rd_addr_b  in  ADDR_WIDTH each  addresses being read on regfile ports A/B.
REQ-015 fwd_hit_a / fwd_hit_b  out  1 each  a queued write targets rd_addr_a / rd_addr_b.
REQ-016 fwd_data_a / fwd_data_b  out  WIDTH each  value of the youngest queued write to that address.
REQ-017 count  out  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-018 Circular FIFO of DEPTH {addr, data} entries; head pointer, tail pointer, count register.
REQ-019 in_ready = (count < DEPTH); depends only on registered state, never on wr_stall or in_valid.
REQ-020 Push when in_valid && in_ready: entry written at tail on the rising edge; tail wraps DEPTH-1 -> 0.
REQ-021 we_d = (count != 0) && !wr_stall; addr_d/d always show head entry (don't-care data when empty).
REQ-022 Pop when we_d is 1: head advances on the same rising edge the regfile samples the write; head wraps DEPTH-1 -> 0.
REQ-023 Latency: write pushed into empty queue at edge N appears on we_d in cycle N+1 (no combinational pass-through).
REQ-024 Simultaneous push and pop: count unchanged, both pointers advance; valid in any non-full state.
REQ-025 Full (count == DEPTH): in_ready = 0, in_valid ignored even if a pop occurs that cycle.
REQ-026 wr_stall held: queue contents frozen, pushes continue until full.
REQ-027 Writes leave in arrival order; two queued writes to the same address both reach the regfile, oldest first.
REQ-028 Bypass: fwd_hit_x = 1 iff a valid entry has addr == rd_addr_x; fwd_data_x = data of the youngest such entry; purely combinational from state and rd_addr_x.
REQ-029 No match: fwd_hit_x = 0, fwd_data_x = 0.
REQ-030 The entry being popped in the current cycle still participates in bypass.

Reset
REQ-031 rst asserted: head = tail = 0, count = 0 immediately, independent of clk.
REQ-032 Under reset: in_ready = 1 (DEPTH > 0), we_d = 0, fwd_hit_a = fwd_hit_b = 0, fwd_data_a = fwd_data_b = 0, count = 0; entry storage need not be cleared.
REQ-033 Reset mid-operation discards all queued writes; none reach the regfile.

Configuration
REQ-034 Macro WBQ_BYPASS_EN: defined -> REQ-028..REQ-030 bypass logic present.
REQ-035 WBQ_BYPASS_EN undefined -> no comparators; fwd_hit_a/b tied 0, fwd_data_a/b tied 0; ports remain.

Verification
REQ-036 After reset: count=0, we_d=0, in_ready=1, fwd_hit_a=0 for rd_addr_a=0..REG_COUNT-1.
REQ-037 Push (5, 0xA5) into empty queue, wr_stall=0 -> next cycle we_d=1, addr_d=5, d=0xA5; following cycle count=0.
REQ-038 wr_stall=1, push (1,10),(2,20),(3,30),(4,40),(5,50) -> in_ready=0 after 4th push, count=4, 5th not accepted; release stall -> regs 1,2,3,4 written in order over 4 cycles.
REQ-039 wr_stall=1, push (7,0x11) then (7,0x22), rd_addr_b=7 -> fwd_hit_b=1, fwd_data_b=0x22 (0 and 0 if WBQ_BYPASS_EN undefined).
REQ-040 Full queue, stall released while in_valid=1 -> pop occurs, push refused that cycle, accepted next cycle; count 4->3->3.
REQ-041 Assert rst asynchronously between edges with count=3 -> count=0 and we_d=0 before next edge; no further regfile writes.

Source files
------------

// File: rtl/wb_queue_if.sv
// Port bundle for wb_queue: producer handshake, regfile write port, bypass read taps.
// slave = the queue itself, master = the surrounding pipeline / bench.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef REG_COUNT
`define REG_COUNT 32
`endif

interface wb_queue_if #(
  parameter int WIDTH     = `WORD_WIDTH,
  parameter int REG_COUNT = `REG_COUNT,
  parameter int DEPTH     = 4
);
  localparam int ADDR_WIDTH = $clog2(REG_COUNT);
  localparam int CW         = $clog2(DEPTH) + 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [WIDTH-1:0]      in_data;
  logic                  wr_stall;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  we_d;
  logic [WIDTH-1:0]      d;
  logic [ADDR_WIDTH-1:0] rd_addr_a;
  logic [ADDR_WIDTH-1:0] rd_addr_b;
  logic                  fwd_hit_a;
  logic                  fwd_hit_b;
  logic [WIDTH-1:0]      fwd_data_a;
  logic [WIDTH-1:0]      fwd_data_b;
  logic [CW-1:0]         count;

  modport slave (
    input  in_valid, in_addr, in_data, wr_stall, rd_addr_a, rd_addr_b,
    output in_ready, addr_d, we_d, d, fwd_hit_a, fwd_hit_b, fwd_data_a, fwd_data_b, count
  );

  modport master (
    output in_valid, in_addr, in_data, wr_stall, rd_addr_a, rd_addr_b,
    input  in_ready, addr_d, we_d, d, fwd_hit_a, fwd_hit_b, fwd_data_a, fwd_data_b, count
  );
endinterface

// File: rtl/wb_queue.sv
// Write-back queue: circular FIFO of {addr, data} register writes in front of a regfile port.
// Define WBQ_BYPASS_EN to add read-port forwarding of the youngest queued write per address.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef REG_COUNT
`define REG_COUNT 32
`endif

`ifdef WBQ_BYPASS_EN
// Per-entry address match against both read ports.
module wbq_match #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  vld,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic                  hit_a,
  output logic                  hit_b
);
  assign hit_a = vld && (addr == rd_addr_a);
  assign hit_b = vld && (addr == rd_addr_b);
endmodule
`endif

module wb_queue #(
  parameter int WIDTH     = `WORD_WIDTH,
  parameter int REG_COUNT = `REG_COUNT,
  parameter int DEPTH     = 4
) (
  input  logic         clk,
  input  logic         rst,
  wb_queue_if.slave    bus
);
  localparam int ADDR_WIDTH = $clog2(REG_COUNT);
  localparam int PW         = $clog2(DEPTH);
  localparam int CW         = PW + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;

  // Ready comes from registered state only, so a same-cycle pop never frees a slot.
  assign bus.in_ready = (count < CW'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (count != '0) && !bus.wr_stall;

  assign bus.we_d   = pop;
  assign bus.addr_d = mem[head].addr;
  assign bus.d      = mem[head].data;
  assign bus.count  = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is left unreset; validity is carried entirely by head/count.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{addr: bus.in_addr, data: bus.in_data};
  end

`ifdef WBQ_BYPASS_EN
  logic [DEPTH-1:0] slot_vld;
  logic [DEPTH-1:0] hit_a;
  logic [DEPTH-1:0] hit_b;
  logic             fwd_hit_a;
  logic             fwd_hit_b;
  logic [WIDTH-1:0] fwd_data_a;
  logic [WIDTH-1:0] fwd_data_b;

  // A slot is live when its distance from head is below count.
  always_comb begin
    logic [PW-1:0] age;
    age      = '0;
    slot_vld = '0;
    for (int j = 0; j < DEPTH; j++) begin
      age         = PW'(j) - head;
      slot_vld[j] = ({1'b0, age} < count);
    end
  end

  for (genvar j = 0; j < DEPTH; j++) begin : g_match
    wbq_match #(.ADDR_WIDTH(ADDR_WIDTH)) u_match (
      .vld       (slot_vld[j]),
      .addr      (mem[j].addr),
      .rd_addr_a (bus.rd_addr_a),
      .rd_addr_b (bus.rd_addr_b),
      .hit_a     (hit_a[j]),
      .hit_b     (hit_b[j])
    );
  end

  // Walk oldest to youngest so the last hit seen is the youngest write.
  always_comb begin
    logic [PW-1:0] slot;
    slot       = '0;
    fwd_hit_a  = 1'b0;
    fwd_hit_b  = 1'b0;
    fwd_data_a = '0;
    fwd_data_b = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head + PW'(k);
      if (hit_a[slot]) begin
        fwd_hit_a  = 1'b1;
        fwd_data_a = mem[slot].data;
      end
      if (hit_b[slot]) begin
        fwd_hit_b  = 1'b1;
        fwd_data_b = mem[slot].data;
      end
    end
  end

  assign bus.fwd_hit_a  = fwd_hit_a;
  assign bus.fwd_hit_b  = fwd_hit_b;
  assign bus.fwd_data_a = fwd_data_a;
  assign bus.fwd_data_b = fwd_data_b;
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^{bus.rd_addr_a, bus.rd_addr_b};

  assign bus.fwd_hit_a  = 1'b0;
  assign bus.fwd_hit_b  = 1'b0;
  assign bus.fwd_data_a = '0;
  assign bus.fwd_data_b = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: per-cycle vector table plus reset corner sequences.
module tb_wb_queue;
  localparam int WIDTH     = 32;
  localparam int REG_COUNT = 32;
  localparam int DEPTH     = 4;
  localparam int AW        = $clog2(REG_COUNT);
  localparam int CW        = $clog2(DEPTH) + 1;
`ifdef WBQ_BYPASS_EN
  localparam int BP = 1;
`else
  localparam int BP = 0;
`endif

  logic clk;
  logic rst;

  wb_queue_if #(.WIDTH(WIDTH), .REG_COUNT(REG_COUNT), .DEPTH(DEPTH)) bus ();

  wb_queue #(.WIDTH(WIDTH), .REG_COUNT(REG_COUNT), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs for one cycle and the outputs expected in that same cycle (before its edge).
  typedef struct {
    int v; int a; int dt; int st; int ra; int rb;
    int rdy; int we; int ad; int d; int cnt;
    int ha; int da; int hb; int db;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];
  int   npass;
  int   ntotal;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
  endtask

  task automatic chk_outputs(input int i, input vec_t t);
    chk("in_ready",   i, 32'(bus.in_ready),   32'(t.rdy));
    chk("we_d",       i, 32'(bus.we_d),       32'(t.we));
    chk("count",      i, 32'(bus.count),      32'(t.cnt));
    if (t.we != 0) begin
      chk("addr_d", i, 32'(bus.addr_d), 32'(t.ad));
      chk("d",      i, bus.d,           32'(t.d));
    end
    chk("fwd_hit_a",  i, 32'(bus.fwd_hit_a),  32'(t.ha));
    chk("fwd_data_a", i, bus.fwd_data_a,      32'(t.da));
    chk("fwd_hit_b",  i, 32'(bus.fwd_hit_b),  32'(t.hb));
    chk("fwd_data_b", i, bus.fwd_data_b,      32'(t.db));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checked", npass, ntotal);
    $fatal(1);
  end

  initial begin
    npass  = 0;
    ntotal = 0;
    //          v  a   dt     st ra  rb  rdy we ad  d      cnt ha  da         hb  db
    // single write, one-cycle latency, bypass sees the entry being popped
    vecs[0]  = '{1, 5, 'hA5,  0, 5,  0,  1,  0, 0,  0,     0,  0,  0,         0,  0};
    vecs[1]  = '{0, 0, 0,     0, 5,  0,  1,  1, 5,  'hA5,  1,  BP, BP*'hA5,   0,  0};
    vecs[2]  = '{0, 0, 0,     0, 5,  0,  1,  0, 0,  0,     0,  0,  0,         0,  0};
    // stalled fill: fifth write refused, then drain in order
    vecs[3]  = '{1, 1, 10,    1, 0,  0,  1,  0, 0,  0,     0,  0,  0,         0,  0};
    vecs[4]  = '{1, 2, 20,    1, 1,  0,  1,  0, 0,  0,     1,  BP, BP*10,     0,  0};
    vecs[5]  = '{1, 3, 30,    1, 0,  0,  1,  0, 0,  0,     2,  0,  0,         0,  0};
    vecs[6]  = '{1, 4, 40,    1, 0,  0,  1,  0, 0,  0,     3,  0,  0,         0,  0};
    vecs[7]  = '{1, 5, 50,    1, 4,  5,  0,  0, 0,  0,     4,  BP, BP*40,     0,  0};
    vecs[8]  = '{0, 0, 0,     0, 0,  0,  0,  1, 1,  10,    4,  0,  0,         0,  0};
    vecs[9]  = '{0, 0, 0,     0, 0,  0,  1,  1, 2,  20,    3,  0,  0,         0,  0};
    vecs[10] = '{0, 0, 0,     0, 0,  0,  1,  1, 3,  30,    2,  0,  0,         0,  0};
    vecs[11] = '{0, 0, 0,     0, 0,  0,  1,  1, 4,  40,    1,  0,  0,         0,  0};
    vecs[12] = '{0, 0, 0,     0, 0,  0,  1,  0, 0,  0,     0,  0,  0,         0,  0};
    // two writes to r7: youngest forwarded
    vecs[13] = '{1, 7, 'h11,  1, 0,  7,  1,  0, 0,  0,     0,  0,  0,         0,  0};
    vecs[14] = '{1, 7, 'h22,  1, 0,  7,  1,  0, 0,  0,     1,  0,  0,         BP, BP*'h11};
    vecs[15] = '{0, 0, 0,     1, 7,  7,  1,  0, 0,  0,     2,  BP, BP*'h22,   BP, BP*'h22};
    // fill to full across the pointer wrap
    vecs[16] = '{1, 8, 'h33,  1, 0,  0,  1,  0, 0,  0,     2,  0,  0,         0,  0};
    vecs[17] = '{1, 9, 'h44,  1, 0,  0,  1,  0, 0,  0,     3,  0,  0,         0,  0};
    vecs[18] = '{1, 10,'h55,  1, 0,  9,  0,  0, 0,  0,     4,  0,  0,         BP, BP*'h44};
    // full + stall release with in_valid held: pop only, then push+pop
    vecs[19] = '{1, 10,'h55,  0, 0,  0,  0,  1, 7,  'h11,  4,  0,  0,         0,  0};
    vecs[20] = '{1, 10,'h55,  0, 0,  0,  1,  1, 7,  'h22,  3,  0,  0,         0,  0};
    vecs[21] = '{0, 0, 0,     1, 10, 7,  1,  0, 0,  0,     3,  BP, BP*'h55,   0,  0};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_addr   = '0;
    bus.in_data   = '0;
    bus.wr_stall  = 1'b0;
    bus.rd_addr_a = '0;
    bus.rd_addr_b = '0;

    // reset state, bypass scan across the whole register space
    @(negedge clk);
    chk("rst count",    -1, 32'(bus.count),    32'd0);
    chk("rst we_d",     -1, 32'(bus.we_d),     32'd0);
    chk("rst in_ready", -1, 32'(bus.in_ready), 32'd1);
    for (int a = 0; a < REG_COUNT; a++) begin
      bus.rd_addr_a = AW'(a);
      bus.rd_addr_b = AW'(a);
      #1;
      chk("rst fwd_hit_a",  a, 32'(bus.fwd_hit_a), 32'd0);
      chk("rst fwd_data_a", a, bus.fwd_data_a,     32'd0);
      chk("rst fwd_hit_b",  a, 32'(bus.fwd_hit_b), 32'd0);
    end
    bus.rd_addr_a = '0;
    bus.rd_addr_b = '0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus.in_valid  = vecs[i].v[0];
      bus.in_addr   = AW'(vecs[i].a);
      bus.in_data   = WIDTH'(vecs[i].dt);
      bus.wr_stall  = vecs[i].st[0];
      bus.rd_addr_a = AW'(vecs[i].ra);
      bus.rd_addr_b = AW'(vecs[i].rb);
      #1;
      chk_outputs(i, vecs[i]);
    end

    // async reset between edges with three writes queued and the port free
    #1;
    bus.in_valid = 1'b0;
    bus.wr_stall = 1'b0;
    #1;
    chk("pre-rst we_d",  100, 32'(bus.we_d),  32'd1);
    chk("pre-rst count", 100, 32'(bus.count), 32'd3);
    rst = 1'b1;
    #1;
    chk("async rst count",    101, 32'(bus.count),     32'd0);
    chk("async rst we_d",     101, 32'(bus.we_d),      32'd0);
    chk("async rst in_ready", 101, 32'(bus.in_ready),  32'd1);
    chk("async rst fwd_hit_a",101, 32'(bus.fwd_hit_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk("post-rst we_d",  102 + c, 32'(bus.we_d),  32'd0);
      chk("post-rst count", 102 + c, 32'(bus.count), 32'd0);
    end

    // recovery: a fresh write after reset drains normally
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_addr  = AW'(3);
    bus.in_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("recover we_d",   110, 32'(bus.we_d),   32'd1);
    chk("recover addr_d", 110, 32'(bus.addr_d), 32'd3);
    chk("recover d",      110, bus.d,           32'hDEAD_BEEF);
    @(negedge clk);
    #1;
    chk("recover count",  111, 32'(bus.count),  32'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
